// File: rtl/mp_add_seq.sv
// mp_add_seq: byte-serial multi-precision add/subtract sequencer over one shared 8-bit adder slice; MP_ADD_OVF_EN adds out_ovf
module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*WORDS-1:0] in_a,
  input  logic [8*WORDS-1:0] in_b,
  input  logic               in_cin,
  input  logic               in_sub,
  output logic [7:0]         add_a,
  output logic [7:0]         add_b,
  output logic               add_cin,
  input  logic [7:0]         add_sum,
  input  logic               add_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*WORDS-1:0] out_sum,
  output logic               out_cout
`ifdef MP_ADD_OVF_EN
  ,
  output logic               out_ovf
`endif
);
  localparam int W  = 8 * WORDS;
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_sum;
  logic           r_carry;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           w_run;
  logic           w_last;
  assign w_run     = r_state == RUN;
  assign w_last    = r_idx == IW'(WORDS - 1);
  assign add_a     = w_run ? r_a[{r_idx, 3'b000} +: 8] : 8'd0;
  assign add_b     = w_run ? r_b[{r_idx, 3'b000} +: 8] : 8'd0;
  assign add_cin   = w_run & r_carry;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_carry;
  // sequencer: latch operands on accept, ripple one byte per cycle, hold result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a        <= in_a;
          r_b        <= in_sub ? ~in_b : in_b;
          r_carry    <= in_sub | in_cin;
          r_idx      <= '0;
          r_sum      <= '0;
          r_in_ready <= 1'b0;
          r_state    <= RUN;
        end
        RUN: begin
          r_sum[{r_idx, 3'b000} +: 8] <= add_sum;
          r_carry <= add_cout;
          r_idx   <= w_last ? r_idx : r_idx + 1'b1;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef MP_ADD_OVF_EN
  logic r_ovf;
  assign out_ovf = r_ovf;
  // signed overflow captured from the MSB byte on the last ripple step
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if (r_state == IDLE && in_valid) r_ovf <= 1'b0;
    else if (w_run && w_last) r_ovf <= (r_a[W-1] == r_b[W-1]) && (add_sum[7] != r_a[W-1]);
  end
`endif
endmodule
